// File: rtl/serial_divisibility_by_n_using_fsm.sv
// Serial divisibility tester: running remainder mod DIVISOR of a framed bit stream, plus saturating bit count.
// Latency: 1 cycle from an accepted beat to the out_valid pulse and the updated outputs.
// Backpressure: none; every in_valid beat is accepted. Macro SERIAL_DIV_LSB_FIRST_EN adds an LSB-first mode.
module serial_divisibility_by_n_using_fsm #(
    parameter int DIVISOR  = 5,
    parameter int MAX_BITS = 16,
    localparam int RW = $clog2(DIVISOR),
    localparam int CW = $clog2(MAX_BITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_first,
    input  logic          new_bit,
`ifdef SERIAL_DIV_LSB_FIRST_EN
    input  logic          lsb_first,
`endif
    output logic          out_valid,
    output logic [RW-1:0] remainder,
    output logic          div_by_n,
    output logic [CW-1:0] bit_count
);

    // Parameter sanity: the single conditional subtract and the widths assume these ranges.
    if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
        $error("serial_divisibility_by_n_using_fsm: DIVISOR must be in 2..255");
    end
    if (MAX_BITS < 1) begin : g_bad_max_bits
        $error("serial_divisibility_by_n_using_fsm: MAX_BITS must be >= 1");
    end

    localparam logic [RW:0]   DIV_T = (RW + 1)'(DIVISOR);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BITS);

    // The remainder register is the FSM state; in_first restarts from remainder 0.
    logic [RW-1:0] base;
    logic [RW:0]   msb_t;
    logic [RW-1:0] msb_next;
    logic [RW-1:0] rem_next;
    logic [CW-1:0] cnt_next;

`ifdef SERIAL_DIV_LSB_FIRST_EN
    localparam logic [RW-1:0] ONE_W = RW'(1);

    logic [RW-1:0] weight;
    logic [RW-1:0] w_cur;
    logic [RW:0]   lsb_t;
    logic [RW-1:0] lsb_next;
    logic [RW:0]   w_t;
    logic [RW-1:0] w_dbl;
    logic [RW-1:0] w_next;
`endif

    // Next-state arithmetic: both operands stay below DIVISOR, so one subtract folds the sum back into range.
    always_comb begin
        base     = in_first ? '0 : remainder;
        msb_t    = {base, new_bit};
        msb_next = (msb_t >= DIV_T) ? RW'(msb_t - DIV_T) : msb_t[RW-1:0];
        cnt_next = in_first ? CW'(1)
                 : ((bit_count == MAX_C) ? bit_count : bit_count + CW'(1));
`ifdef SERIAL_DIV_LSB_FIRST_EN
        // The first bit of a number always carries weight 1; later bits carry 2^k mod DIVISOR.
        w_cur    = in_first ? ONE_W : weight;
        lsb_t    = {1'b0, base} + (new_bit ? {1'b0, w_cur} : '0);
        lsb_next = (lsb_t >= DIV_T) ? RW'(lsb_t - DIV_T) : lsb_t[RW-1:0];
        w_t      = {w_cur, 1'b0};
        w_dbl    = (w_t >= DIV_T) ? RW'(w_t - DIV_T) : w_t[RW-1:0];
        if (lsb_first) begin
            rem_next = lsb_next;
            w_next   = w_dbl;
        end else begin
            rem_next = msb_next;
            w_next   = w_cur;
        end
`else
        rem_next = msb_next;
`endif
    end

    // State and registered outputs; reset wins over a simultaneous beat, idle cycles hold everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            remainder <= '0;
            div_by_n  <= 1'b1;
            bit_count <= '0;
`ifdef SERIAL_DIV_LSB_FIRST_EN
            weight    <= ONE_W;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                remainder <= rem_next;
                div_by_n  <= (rem_next == '0);
                bit_count <= cnt_next;
`ifdef SERIAL_DIV_LSB_FIRST_EN
                weight    <= w_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_divisibility_by_n_using_fsm.sv
// Bench for the serial divisibility tester: three instances (D5/M16, D7/M16, D5/M4) share one stimulus.
// An arithmetic model (value mod D, min-saturated count) is compared every cycle; directed vectors
// carry hand-computed literal expectations.
module tb_serial_divisibility_by_n_using_fsm;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic in_valid  = 1'b0;
    logic in_first  = 1'b0;
    logic new_bit   = 1'b0;
    logic lsb_first = 1'b0;

    logic       ov_a, div_a, ov_b, div_b, ov_c, div_c;
    logic [2:0] rem_a, rem_b, rem_c;
    logic [4:0] cnt_a, cnt_b;
    logic [2:0] cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_divisibility_by_n_using_fsm #(.DIVISOR(5), .MAX_BITS(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .new_bit(new_bit),
`ifdef SERIAL_DIV_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .out_valid(ov_a), .remainder(rem_a), .div_by_n(div_a), .bit_count(cnt_a));

    serial_divisibility_by_n_using_fsm #(.DIVISOR(7), .MAX_BITS(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .new_bit(new_bit),
`ifdef SERIAL_DIV_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .out_valid(ov_b), .remainder(rem_b), .div_by_n(div_b), .bit_count(cnt_b));

    serial_divisibility_by_n_using_fsm #(.DIVISOR(5), .MAX_BITS(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .new_bit(new_bit),
`ifdef SERIAL_DIV_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .out_valid(ov_c), .remainder(rem_c), .div_by_n(div_c), .bit_count(cnt_c));

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int D_T[3] = '{5, 7, 5};
    int M_T[3] = '{16, 16, 4};
    int m_rem[3];
    int m_cnt[3];
    int m_pos[3];
    int m_ov   = 0;
    bit live   = 1'b0;

    function automatic int pow2mod(input int p, input int d);
        int r = 1 % d;
        for (int i = 0; i < p; i++) r = (r * 2) % d;
        return r;
    endfunction

    // Model update at each rising edge from the inputs held stable across it.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k < 3; k++) begin
                    m_rem[k] = 0; m_cnt[k] = 0; m_pos[k] = 0;
                end
                m_ov = 0;
                live = 1'b1;
            end else begin
                m_ov = int'(in_valid);
                if (in_valid) begin
                    for (int k = 0; k < 3; k++) begin
                        if (in_first) begin
                            m_rem[k] = 0; m_cnt[k] = 0; m_pos[k] = 0;
                        end
                        if (lsb_first) begin
                            m_rem[k] = (m_rem[k] + (new_bit ? pow2mod(m_pos[k], D_T[k]) : 0)) % D_T[k];
                            m_pos[k] = m_pos[k] + 1;
                        end else begin
                            m_rem[k] = (m_rem[k] * 2 + int'(new_bit)) % D_T[k];
                        end
                        m_cnt[k] = (m_cnt[k] + 1 > M_T[k]) ? M_T[k] : m_cnt[k] + 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison on the falling edge, once the model has seen reset.
    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                cmp("a_rem", int'(rem_a), m_rem[0]);
                cmp("a_div", int'(div_a), int'(m_rem[0] == 0));
                cmp("a_cnt", int'(cnt_a), m_cnt[0]);
                cmp("a_ov",  int'(ov_a),  m_ov);
                cmp("b_rem", int'(rem_b), m_rem[1]);
                cmp("b_div", int'(div_b), int'(m_rem[1] == 0));
                cmp("b_cnt", int'(cnt_b), m_cnt[1]);
                cmp("b_ov",  int'(ov_b),  m_ov);
                cmp("c_rem", int'(rem_c), m_rem[2]);
                cmp("c_div", int'(div_c), int'(m_rem[2] == 0));
                cmp("c_cnt", int'(cnt_c), m_cnt[2]);
                cmp("c_ov",  int'(ov_c),  m_ov);
            end
        end
    end

    // One beat (or idle) held across exactly one rising edge; returns 1 time unit after it.
    task automatic step(input logic v, input logic f, input logic b);
        in_valid = v; in_first = f; new_bit = b;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int t1_bits[4] = '{1, 0, 1, 0};
        int t1_rem[4]  = '{1, 2, 0, 0};
        int t1_div[4]  = '{0, 0, 1, 1};
        int t2_rem[3]  = '{1, 3, 0};
        int t4_cnt[6]  = '{1, 2, 3, 4, 4, 4};
        int pulses;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_rem", int'(rem_a), 0);
        cmp("rst_div", int'(div_a), 1);
        cmp("rst_cnt", int'(cnt_a), 0);
        cmp("rst_ov",  int'(ov_a),  0);
        rst = 1'b0;

        // D=5, MSB-first 1,0,1,0
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i == 0, t1_bits[i][0]);
            cmp("t1_rem", int'(rem_a), t1_rem[i]);
            cmp("t1_div", int'(div_a), t1_div[i]);
            cmp("t1_cnt", int'(cnt_a), i + 1);
            cmp("t1_ov",  int'(ov_a),  1);
        end

        // D=7, 1,1,1 with idle gaps carrying junk on in_first/new_bit
        step(1'b0, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, i == 0, 1'b1);
            cmp("t2_rem", int'(rem_b), t2_rem[i]);
            pulses += int'(ov_b);
            step(1'b0, 1'b1, 1'b1);
            cmp("t2_hold", int'(rem_b), t2_rem[i]);
            cmp("t2_idle_ov", int'(ov_b), 0);
            pulses += int'(ov_b);
        end
        cmp("t2_pulses", pulses, 3);

        // D=5, 1,1 then restart with in_first
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        cmp("t3_rem3", int'(rem_a), 3);
        step(1'b1, 1'b1, 1'b1);
        cmp("t3_rem1", int'(rem_a), 1);
        cmp("t3_cnt1", int'(cnt_a), 1);

        // MAX_BITS=4, six ones (63 mod 5 = 3)
        for (int i = 0; i < 6; i++) begin
            step(1'b1, i == 0, 1'b1);
            cmp("t4_cnt", int'(cnt_c), t4_cnt[i]);
        end
        cmp("t4_rem", int'(rem_c), 3);
        cmp("t4_cnt_a", int'(cnt_a), 6);

        // Reset coincident with an accepted beat mid-number
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        cmp("t5_rem", int'(rem_a), 0);
        cmp("t5_div", int'(div_a), 1);
        cmp("t5_cnt", int'(cnt_a), 0);
        cmp("t5_ov",  int'(ov_a),  0);
        rst = 1'b0;

        // First number after reset without in_first
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        cmp("t6_rem", int'(rem_a), 3);
        cmp("t6_cnt", int'(cnt_a), 2);

        // Mixed stream checked by the model
        for (int i = 0; i < 60; i++) begin
            step((i % 4) != 3, (i % 13) == 0, ((i * 5 + 1) % 7) > 3);
        end

`ifdef SERIAL_DIV_LSB_FIRST_EN
        // LSB-first, D=5, bits 0,1,0,1 (value 10)
        begin
            int t7_bits[4] = '{0, 1, 0, 1};
            int t7_rem[4]  = '{0, 2, 2, 0};
            int t7_div[4]  = '{1, 0, 0, 1};
            lsb_first = 1'b1;
            for (int i = 0; i < 4; i++) begin
                step(1'b1, i == 0, t7_bits[i][0]);
                cmp("t7_rem", int'(rem_a), t7_rem[i]);
                cmp("t7_div", int'(div_a), t7_div[i]);
            end
            for (int i = 0; i < 30; i++) begin
                step((i % 5) != 2, (i % 11) == 0, ((i * 3 + 2) % 5) > 1);
            end
            lsb_first = 1'b0;
            step(1'b1, 1'b1, 1'b1);
        end
`endif

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
